gamma_ctrl: RTL and testbench



---
 rtl/gamma_pkg.sv | 20 ++
 rtl/gamma_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_gamma_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gamma_pkg.sv
// gamma_pkg: table geometry, channel bases and sequencer state encoding
// shared by the gamma LUT controller.
package gamma_pkg;

    localparam int GAMMA_ENTRIES = 768;
    localparam int GAMMA_AW      = 10;

    localparam logic [GAMMA_AW-1:0] GAMMA_BASE_R   = 10'd0;
    localparam logic [GAMMA_AW-1:0] GAMMA_BASE_G   = 10'd256;
    localparam logic [GAMMA_AW-1:0] GAMMA_BASE_B   = 10'd512;
    localparam logic [GAMMA_AW-1:0] GAMMA_LAST_IDX = 10'(GAMMA_ENTRIES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        LOAD  = 2'd2,
        DRAIN = 2'd3
    } gamma_state_t;

endpackage

// File: rtl/gamma_ctrl.sv
// gamma_ctrl: gamma LUT load/fill sequencer with vblank-aligned table enable.
// The identity-ramp fill path (FILL state, default_req) exists only under GAMMA_DEFAULT_FILL_EN.
//
// state | meaning
// IDLE  | no table traffic; a pending curve commits on the next vblank rise
// FILL  | writing the identity ramp, one entry per cycle
// LOAD  | accepting host bytes, one table write per accepted byte
// DRAIN | stream overran the table; discard bytes until host_last
module gamma_ctrl
    import gamma_pkg::*;
(
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                load_start,
    input  logic                default_req,
    input  logic                host_valid,
    output logic                host_ready,
    input  logic [7:0]          host_data,
    input  logic                host_last,
    input  logic                gamma_en_req,
    input  logic                vblank,
    output logic                gamma_wr,
    output logic [GAMMA_AW-1:0] gamma_wr_addr,
    output logic [7:0]          gamma_value,
    output logic                gamma_en,
    output logic                busy,
    output logic                err
);

    gamma_state_t        state, state_nxt;
    logic [GAMMA_AW-1:0] idx, idx_nxt;
    logic                table_valid, table_valid_nxt;
    logic                pending, pending_nxt;
    logic                err_nxt;
    logic                gamma_en_nxt;
    logic                wr_nxt;
    logic [GAMMA_AW-1:0] addr_nxt;
    logic [7:0]          value_nxt;
    logic                vblank_q;
    logic                vblank_rise;
    logic                commit;
    logic                accept;
    logic                boot;

`ifdef GAMMA_DEFAULT_FILL_EN
    logic boot_nxt;

    // One-shot flag so the identity ramp is written right after reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            boot <= 1'b1;
        end else begin
            boot <= boot_nxt;
        end
    end
`else
    logic unused_default_req;
    assign unused_default_req = default_req;
    assign boot               = 1'b0;
`endif

    assign accept      = host_valid & host_ready;
    assign vblank_rise = vblank & ~vblank_q;
    // A write still on the bus this cycle has not landed; defer commit a frame.
    assign commit      = vblank_rise & pending & ~gamma_wr;

    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        table_valid_nxt = table_valid;
        pending_nxt     = pending;
        err_nxt         = err;
        gamma_en_nxt    = gamma_en;
        wr_nxt          = 1'b0;
        addr_nxt        = gamma_wr_addr;
        value_nxt       = gamma_value;
`ifdef GAMMA_DEFAULT_FILL_EN
        boot_nxt        = 1'b0;
`endif

        if (vblank_rise) begin
            if (commit) begin
                table_valid_nxt = 1'b1;
                pending_nxt     = 1'b0;
            end
            gamma_en_nxt = gamma_en_req & (table_valid | commit);
        end

        case (state)
            IDLE: begin
                if (load_start) begin
                    state_nxt       = LOAD;
                    idx_nxt         = '0;
                    table_valid_nxt = 1'b0;
                    pending_nxt     = 1'b0;
                    err_nxt         = 1'b0;
                    gamma_en_nxt    = 1'b0;
                end
`ifdef GAMMA_DEFAULT_FILL_EN
                else if (default_req || boot) begin
                    state_nxt       = FILL;
                    idx_nxt         = '0;
                    table_valid_nxt = 1'b0;
                    pending_nxt     = 1'b0;
                    gamma_en_nxt    = 1'b0;
                end
`endif
            end

`ifdef GAMMA_DEFAULT_FILL_EN
            FILL: begin
                if (load_start) begin
                    state_nxt       = LOAD;
                    idx_nxt         = '0;
                    table_valid_nxt = 1'b0;
                    pending_nxt     = 1'b0;
                    err_nxt         = 1'b0;
                    gamma_en_nxt    = 1'b0;
                end else begin
                    wr_nxt    = 1'b1;
                    addr_nxt  = idx;
                    value_nxt = idx[7:0];
                    if (idx == GAMMA_LAST_IDX) begin
                        state_nxt   = IDLE;
                        pending_nxt = 1'b1;
                    end else begin
                        idx_nxt = idx + 10'd1;
                    end
                end
            end
`endif

            LOAD: begin
                if (accept) begin
                    wr_nxt    = 1'b1;
                    addr_nxt  = idx;
                    value_nxt = host_data;
                    if (host_last) begin
                        state_nxt = IDLE;
                        if (idx == GAMMA_LAST_IDX) begin
                            pending_nxt = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else if (idx == GAMMA_LAST_IDX) begin
                        err_nxt   = 1'b1;
                        state_nxt = DRAIN;
                    end else begin
                        idx_nxt = idx + 10'd1;
                    end
                end
            end

            DRAIN: begin
                if (accept && host_last) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            table_valid   <= 1'b0;
            pending       <= 1'b0;
            err           <= 1'b0;
            gamma_en      <= 1'b0;
            gamma_wr      <= 1'b0;
            gamma_wr_addr <= '0;
            gamma_value   <= '0;
            host_ready    <= 1'b0;
            busy          <= 1'b0;
            vblank_q      <= 1'b0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            table_valid   <= table_valid_nxt;
            pending       <= pending_nxt;
            err           <= err_nxt;
            gamma_en      <= gamma_en_nxt;
            gamma_wr      <= wr_nxt;
            gamma_wr_addr <= addr_nxt;
            gamma_value   <= value_nxt;
            host_ready    <= (state_nxt == LOAD) || (state_nxt == DRAIN);
            busy          <= (state_nxt != IDLE);
            vblank_q      <= vblank;
        end
    end

endmodule

// File: tb/tb_gamma_ctrl.sv
// tb_gamma_ctrl: directed bench for gamma_ctrl; identity-fill steps are
// included when GAMMA_DEFAULT_FILL_EN is defined.
module tb_gamma_ctrl;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       load_start = 1'b0;
    logic       default_req = 1'b0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic [7:0] host_data = 8'h00;
    logic       host_last = 1'b0;
    logic       gamma_en_req = 1'b1;
    logic       vblank = 1'b0;
    logic       gamma_wr;
    logic [9:0] gamma_wr_addr;
    logic [7:0] gamma_value;
    logic       gamma_en;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    gamma_ctrl dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .load_start    (load_start),
        .default_req   (default_req),
        .host_valid    (host_valid),
        .host_ready    (host_ready),
        .host_data     (host_data),
        .host_last     (host_last),
        .gamma_en_req  (gamma_en_req),
        .vblank        (vblank),
        .gamma_wr      (gamma_wr),
        .gamma_wr_addr (gamma_wr_addr),
        .gamma_value   (gamma_value),
        .gamma_en      (gamma_en),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_host_ready"}, host_ready, 0);
        chk({tag, "_gamma_wr"}, gamma_wr, 0);
        chk({tag, "_addr"}, gamma_wr_addr, 0);
        chk({tag, "_value"}, gamma_value, 0);
        chk({tag, "_gamma_en"}, gamma_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Offer one byte after 'gap' idle cycles; check the write that follows the accepting edge.
    task automatic send_byte(input logic [7:0] d, input logic last, input int exp_addr,
                             input logic exp_write, input int gap);
        for (int g = 0; g < gap; g++) begin
            host_valid = 1'b0;
            cyc();
            chk("gap_no_write", gamma_wr, 0);
        end
        chk("ready_before_byte", host_ready, 1);
        host_valid = 1'b1;
        host_data  = d;
        host_last  = last;
        cyc();
        host_valid = 1'b0;
        host_last  = 1'b0;
        chk("byte_wr", gamma_wr, exp_write);
        if (exp_write) begin
            chk("byte_addr", gamma_wr_addr, exp_addr);
            chk("byte_value", gamma_value, d);
        end
    endtask

    task automatic vpulse();
        vblank = 1'b1;
        cyc();
        vblank = 1'b0;
        cyc();
    endtask

    initial begin
        // Reset values
        cyc();
        cyc();
        chk_reset_outputs("reset");

`ifdef GAMMA_DEFAULT_FILL_EN
        reset = 1'b0;
        cyc();
        chk("boot_fill_busy", busy, 1);
        chk("boot_fill_first_wr", gamma_wr, 0);
        for (int k = 0; k < 768; k++) begin
            cyc();
            chk("fill_wr", gamma_wr, 1);
            chk("fill_addr", gamma_wr_addr, k);
            chk("fill_value", gamma_value, k & 255);
        end
        cyc();
        chk("fill_done_wr", gamma_wr, 0);
        chk("fill_done_busy", busy, 0);
        chk("fill_en_before_vblank", gamma_en, 0);
        vpulse();
        chk("fill_en_after_vblank", gamma_en, 1);

        default_req = 1'b1;
        cyc();
        default_req = 1'b0;
        chk("refill_en_drop", gamma_en, 0);
        chk("refill_busy", busy, 1);
        for (int k = 0; k < 300; k++) begin
            cyc();
            chk("refill_addr", gamma_wr_addr, k);
        end
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        chk("abort_no_write", gamma_wr, 0);
        chk("abort_ready", host_ready, 1);
        chk("abort_en", gamma_en, 0);
        send_byte(8'h5A, 1'b0, 0, 1'b1, 0);
        chk("abort_en_after_byte", gamma_en, 0);
        reset = 1'b1;
        cyc();
        chk_reset_outputs("reset2");
`endif

        // Full load, value 255-i, random valid gaps
        reset      = 1'b0;
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        chk("load_ready_rise", host_ready, 1);
        chk("load_busy", busy, 1);
        chk("load_en_low", gamma_en, 0);
        for (int i = 0; i < 768; i++) begin
            send_byte(8'(255 - i), i == 767, i, 1'b1, (i % 37 == 5) ? $urandom_range(3, 1) : 0);
        end
        chk("load_done_ready", host_ready, 0);
        chk("load_done_busy", busy, 0);
        chk("load_done_err", err, 0);
        chk("load_done_en", gamma_en, 0);
        // vblank rising while the final write is still on the bus must not commit
        vblank = 1'b1;
        cyc();
        chk("final_write_no_commit", gamma_en, 0);
        vblank = 1'b0;
        cyc();
        chk("no_write_after_last", gamma_wr, 0);
        repeat (3) cyc();
        chk("en_waits_for_vblank", gamma_en, 0);
        vblank = 1'b1;
        cyc();
        chk("en_on_vblank_rise", gamma_en, 1);
        vblank = 1'b0;
        cyc();
        chk("en_held", gamma_en, 1);
        gamma_en_req = 1'b0;
        vpulse();
        chk("en_req_low", gamma_en, 0);
        gamma_en_req = 1'b1;
        vpulse();
        chk("en_req_high_again", gamma_en, 1);

`ifndef GAMMA_DEFAULT_FILL_EN
        default_req = 1'b1;
        cyc();
        default_req = 1'b0;
        cyc();
        chk("default_req_ignored_en", gamma_en, 1);
        chk("default_req_ignored_busy", busy, 0);
        chk("default_req_ignored_wr", gamma_wr, 0);
`endif

        // Short stream: host_last on byte 100
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        chk("short_en_drop", gamma_en, 0);
        for (int i = 0; i < 100; i++) begin
            send_byte(8'(i * 3), i == 99, i, 1'b1, (i % 11 == 4) ? 1 : 0);
        end
        chk("short_err", err, 1);
        chk("short_busy", busy, 0);
        chk("short_ready", host_ready, 0);
        for (int v = 0; v < 3; v++) begin
            vpulse();
            chk("short_en_stays_low", gamma_en, 0);
        end
        chk("short_err_sticky", err, 1);

        // Long stream: 800 bytes, host_last on byte 800
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        chk("long_err_cleared", err, 0);
        for (int i = 0; i < 800; i++) begin
            send_byte(8'(i), i == 799, i, i < 768, 0);
            if (i == 767) chk("long_err_at_overrun", err, 1);
        end
        chk("long_ready_drop", host_ready, 0);
        chk("long_busy", busy, 0);
        chk("long_err", err, 1);
        vpulse();
        chk("long_en_low", gamma_en, 0);

        // Reset mid-load at idx 400
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            send_byte(8'(i ^ 8'h3C), 1'b0, i, 1'b1, 0);
        end
        host_valid = 1'b1;
        host_data  = 8'hAA;
        reset      = 1'b1;
        cyc();
        chk_reset_outputs("midload_reset");
        reset = 1'b0;
`ifndef GAMMA_DEFAULT_FILL_EN
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("post_reset_no_write", gamma_wr, 0);
            chk("post_reset_ready", host_ready, 0);
        end
        vpulse();
        chk("post_reset_en", gamma_en, 0);
`endif
        host_valid = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
